// File: rtl/rlbp_s2p_pkg.sv
// Purpose : shared register map, STATUS/CTRL bit positions and frame timeout for the RLBP serial-to-parallel FIFO.
// Latency : n/a (constants only).
// Backpr. : n/a.
package rlbp_s2p_pkg;

   // Register select decoded from wbs_adr_i[3:2]
   typedef enum logic [1:0] {
      REG_DATA   = 2'd0,
      REG_STATUS = 2'd1,
      REG_CTRL   = 2'd2,
      REG_RSV    = 2'd3
   } reg_sel_e;

   // STATUS bit positions (count occupies [DEPTH_LOG2:0])
   localparam int ST_EMPTY = 8;
   localparam int ST_FULL  = 9;
   localparam int ST_OVF   = 10;
   localparam int ST_UNF   = 11;
   localparam int ST_FERR  = 12;

   // CTRL bit positions
   localparam int CTRL_EN      = 0;
   localparam int CTRL_CLR     = 1;
   localparam int CTRL_THR_LSB = 4;

   // Idle cycles tolerated inside a partial word before it is discarded
   localparam int TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/rlbp_sync_fifo.sv
// Purpose : single-clock FIFO, 2**DEPTH_LOG2 entries, head visible combinationally (show-ahead).
// Latency : push visible in count/head the cycle after the push edge.
// Backpr. : push while full (no pop) is dropped and flagged on o_push_drop; pop while empty is ignored.
// Ports   : i_clk/i_rst (sync, active-high), i_clr flush, i_push/i_push_dat, i_pop,
//           o_head_dat, o_full, o_empty, o_count, o_push_drop.
module rlbp_sync_fifo
   import rlbp_s2p_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int DEPTH_LOG2 = 3
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_clr,
   input  logic                  i_push,
   input  logic [WIDTH-1:0]      i_push_dat,
   input  logic                  i_pop,
   output logic [WIDTH-1:0]      o_head_dat,
   output logic                  o_full,
   output logic                  o_empty,
   output logic [DEPTH_LOG2:0]   o_count,
   output logic                  o_push_drop
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

   logic [WIDTH-1:0]      r_mem [DEPTH];
   logic [DEPTH_LOG2-1:0] r_wr;
   logic [DEPTH_LOG2-1:0] r_rd;
   logic [DEPTH_LOG2:0]   r_cnt;

   logic w_do_pop;
   logic w_do_push;

   assign o_full     = (r_cnt == FULL_CNT);
   assign o_empty    = (r_cnt == '0);
   assign o_count    = r_cnt;
   assign o_head_dat = r_mem[r_rd];

   // A pop on a full FIFO frees the slot the same cycle, so a simultaneous push is kept.
   // No pass-through: a pop on an empty FIFO is ignored even if a push lands with it.
   assign w_do_pop    = i_pop & ~o_empty & ~i_clr;
   assign w_do_push   = i_push & (~o_full | w_do_pop) & ~i_clr;
   assign o_push_drop = i_push & o_full & ~w_do_pop & ~i_clr;

   always_ff @(posedge i_clk) begin
      if (w_do_push) begin
         r_mem[r_wr] <= i_push_dat;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_do_push) r_wr <= r_wr + 1'b1;
         if (w_do_pop)  r_rd <= r_rd + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule

// File: rtl/rlbp_s2p_fifo.sv
// Purpose : deserialise RLBP serial codes into WORD_BITS words, buffer them, expose DATA/STATUS/CTRL over Wishbone.
// Latency : last serial bit -> count 1 cycle; Wishbone ack 1 cycle after hit; irq_o lags count by 1 cycle.
// Backpr. : none on the serial side; words arriving at a full FIFO are dropped and OVERFLOW is set.
// Ports   : wb_clk_i/wb_rst_i (sync, active-high), wbs_* Wishbone slave, s_data_in/s_valid_in serial input, irq_o.
// Option  : define RLBP_S2P_TIMEOUT_EN to discard partial words after TIMEOUT_CYCLES idle cycles (FRAME_ERR).
module rlbp_s2p_fifo
   import rlbp_s2p_pkg::*;
#(
   parameter int         WORD_BITS   = 8,
   parameter int         DEPTH_LOG2  = 3,
   parameter logic [3:0] BASE_NIBBLE = 4'h3
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_dat_i,
   input  logic [31:0] wbs_adr_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   input  logic        s_data_in,
   input  logic        s_valid_in,
   output logic        irq_o
);
   localparam int CW = (WORD_BITS > 2) ? $clog2(WORD_BITS) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WORD_BITS - 1);

   // Registers
   logic                 r_ack;
   logic [31:0]          r_dat;
   logic                 r_en;
   logic [3:0]           r_thr;
   logic                 r_ovf;
   logic                 r_unf;
   logic                 r_irq;
   logic [WORD_BITS-2:0] r_shreg;
   logic [CW-1:0]        r_cnt;

   // Wires
   logic                 w_hit, w_acc, w_rd, w_wr;
   reg_sel_e             w_sel;
   logic                 w_pop, w_ctrl_wr, w_clr;
   logic [31:0]          w_w1c;
   logic [31:0]          w_status, w_rdata;
   logic                 w_bit, w_last, w_push;
   logic [WORD_BITS-1:0] w_word, w_head;
   logic                 w_full, w_empty, w_drop;
   logic [DEPTH_LOG2:0]  w_count;
   logic                 w_ferr, w_timeout;
   logic                 w_unused;

   assign w_unused = &{1'b0, wbs_adr_i[27:4], wbs_adr_i[1:0], wbs_sel_i[3:1], wbs_dat_i};

   // The cycle after an ack never accepts, so each transfer has exactly one accept cycle.
   assign w_hit     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:28] == BASE_NIBBLE);
   assign w_acc     = w_hit & ~r_ack;
   assign w_rd      = w_acc & ~wbs_we_i;
   assign w_wr      = w_acc & wbs_we_i;
   assign w_sel     = reg_sel_e'(wbs_adr_i[3:2]);
   assign w_pop     = w_rd & (w_sel == REG_DATA);
   assign w_ctrl_wr = w_wr & (w_sel == REG_CTRL) & wbs_sel_i[0];
   assign w_clr     = w_ctrl_wr & wbs_dat_i[CTRL_CLR];
   assign w_w1c     = (w_wr && (w_sel == REG_STATUS)) ? wbs_dat_i : 32'd0;

   // Deserializer: the completed word includes the bit arriving this cycle.
   assign w_bit  = r_en & s_valid_in;
   assign w_word = {r_shreg, s_data_in};
   assign w_last = (r_cnt == LAST_BIT);
   assign w_push = w_bit & w_last;

   rlbp_sync_fifo #(
      .WIDTH      (WORD_BITS),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_fifo (
      .i_clk       (wb_clk_i),
      .i_rst       (wb_rst_i),
      .i_clr       (w_clr),
      .i_push      (w_push),
      .i_push_dat  (w_word),
      .i_pop       (w_pop),
      .o_head_dat  (w_head),
      .o_full      (w_full),
      .o_empty     (w_empty),
      .o_count     (w_count),
      .o_push_drop (w_drop)
   );

`ifdef RLBP_S2P_TIMEOUT_EN
   logic [15:0] r_idle;
   logic        r_ferr;

   // Idle counter only runs while a partial word is pending and the block is enabled.
   assign w_timeout = r_en & ~w_bit & ~w_clr & (r_cnt != '0)
                      & (r_idle == 16'(TIMEOUT_CYCLES - 1));
   assign w_ferr    = r_ferr;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_idle <= '0;
         r_ferr <= 1'b0;
      end else begin
         if (w_bit || w_clr || w_timeout || (r_cnt == '0)) r_idle <= '0;
         else if (r_en)                                    r_idle <= r_idle + 16'd1;
         r_ferr <= (r_ferr & ~w_w1c[ST_FERR]) | w_timeout;
      end
   end
`else
   assign w_timeout = 1'b0;
   assign w_ferr    = 1'b0;
`endif

   always_comb begin
      w_status                 = '0;
      w_status[DEPTH_LOG2:0]   = w_count;
      w_status[ST_EMPTY]       = w_empty;
      w_status[ST_FULL]        = w_full;
      w_status[ST_OVF]         = r_ovf;
      w_status[ST_UNF]         = r_unf;
      w_status[ST_FERR]        = w_ferr;
   end

   always_comb begin
      w_rdata = '0;
      case (w_sel)
         REG_DATA:   if (!w_empty) w_rdata[WORD_BITS-1:0] = w_head;
         REG_STATUS: w_rdata = w_status;
         REG_CTRL: begin
            w_rdata[CTRL_EN]                      = r_en;
            w_rdata[CTRL_THR_LSB+3:CTRL_THR_LSB]  = r_thr;
         end
         default:    w_rdata = '0;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_ack <= 1'b0;
         r_dat <= '0;
         r_en  <= 1'b0;
         r_thr <= '0;
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
         r_irq <= 1'b0;
      end else begin
         r_ack <= w_acc;
         r_dat <= w_rd ? w_rdata : 32'd0;
         if (w_ctrl_wr) begin
            r_en  <= wbs_dat_i[CTRL_EN];
            r_thr <= wbs_dat_i[CTRL_THR_LSB+3:CTRL_THR_LSB];
         end
         // A new event wins over a W1C landing in the same cycle.
         r_ovf <= (r_ovf & ~w_w1c[ST_OVF]) | w_drop;
         r_unf <= (r_unf & ~w_w1c[ST_UNF]) | (w_pop & w_empty);
         r_irq <= r_en & (r_thr != 4'd0) & (32'(w_count) >= 32'(r_thr));
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i || w_clr || w_timeout) begin
         r_shreg <= '0;
         r_cnt   <= '0;
      end else if (w_bit) begin
         r_shreg <= w_word[WORD_BITS-2:0];
         r_cnt   <= w_last ? '0 : r_cnt + CW'(1);
      end
   end

   assign wbs_ack_o = r_ack;
   assign wbs_dat_o = r_dat;
   assign irq_o     = r_irq;

endmodule

// File: tb/tb_rlbp_s2p_fifo.sv
module tb_rlbp_s2p_fifo;
   localparam logic [3:0] BASE = 4'h3;
   localparam logic [1:0] A_DATA = 2'd0, A_STAT = 2'd1, A_CTRL = 2'd2, A_RSV = 2'd3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
   logic [3:0]  sel = 4'h0;
   logic [31:0] dat_i = '0, adr = '0;
   logic        s_data = 1'b0, s_valid = 1'b0;
   logic        ack, irq;
   logic [31:0] dat_o;

   int n_cmp  = 0;
   int n_fail = 0;

   rlbp_s2p_fifo dut (
      .wb_clk_i  (clk),
      .wb_rst_i  (rst),
      .wbs_stb_i (stb),
      .wbs_cyc_i (cyc),
      .wbs_we_i  (we),
      .wbs_sel_i (sel),
      .wbs_dat_i (dat_i),
      .wbs_adr_i (adr),
      .wbs_ack_o (ack),
      .wbs_dat_o (dat_o),
      .s_data_in (s_data),
      .s_valid_in(s_valid),
      .irq_o     (irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       nm;
      logic        wr;
      logic [1:0]  off;
      logic [31:0] wd;
      logic [3:0]  sl;
      logic [31:0] exp;
   } vec_t;
   vec_t tbl[$];

   function automatic vec_t mk(string nm, logic wr, logic [1:0] off, logic [31:0] wd,
                               logic [3:0] sl, logic [31:0] exp);
      vec_t v;
      v.nm = nm; v.wr = wr; v.off = off; v.wd = wd; v.sl = sl; v.exp = exp;
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic wb(input logic w, input logic [1:0] off, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rd);
      int n;
      cyc = 1'b1; stb = 1'b1; we = w; sel = s; dat_i = d;
      adr = {BASE, 24'h0, off, 2'b00};
      n = 0;
      do begin step(); n++; end while (!ack && n < 8);
      if (!ack) begin
         n_fail++;
         $display("FAIL wb_ack_timeout: got no ack expected ack within 8 cycles");
      end
      rd = dat_o;
      cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; dat_i = '0;
      step();
   endtask

   task automatic rd_reg(input logic [1:0] off, output logic [31:0] rd);
      wb(1'b0, off, 32'h0, 4'hF, rd);
   endtask

   task automatic wr_reg(input logic [1:0] off, input logic [31:0] d);
      logic [31:0] dummy;
      wb(1'b1, off, d, 4'hF, dummy);
   endtask

   task automatic send_bits(input logic [31:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         s_valid = 1'b1;
         s_data  = v[i];
         step();
      end
      s_valid = 1'b0;
      s_data  = 1'b0;
   endtask

   initial begin
      logic [31:0] rd;
      logic [7:0]  w5 [8];
      logic [7:0]  w9;
      logic [10:0] cat;
      logic        any_ack;
      logic [7:0]  q[$];
      logic [7:0]  rw;
      logic [7:0]  exp8;
      int          thr;
      bit          m_ovf, m_unf;

      // ---------------- reset ----------------
      repeat (3) step();
      chk("rst_ack", {31'b0, ack}, 32'h0);
      chk("rst_dat", dat_o, 32'h0);
      chk("rst_irq", {31'b0, irq}, 32'h0);
      rst = 1'b0;
      step();

      // ---------------- register table ----------------
      tbl.push_back(mk("rst_status",      0, A_STAT, 32'h0,          4'hF, 32'h0000_0100));
      tbl.push_back(mk("rst_ctrl",        0, A_CTRL, 32'h0,          4'hF, 32'h0));
      tbl.push_back(mk("rsv_read",        0, A_RSV,  32'h0,          4'hF, 32'h0));
      tbl.push_back(mk("rsv_write",       1, A_RSV,  32'hFFFF_FFFF,  4'hF, 32'h0));
      tbl.push_back(mk("rsv_after_wr",    0, A_RSV,  32'h0,          4'hF, 32'h0));
      tbl.push_back(mk("ctrl_wr_nosel0",  1, A_CTRL, 32'h31,         4'hE, 32'h0));
      tbl.push_back(mk("ctrl_sel0_block", 0, A_CTRL, 32'h0,          4'hF, 32'h0));
      tbl.push_back(mk("ctrl_wr_clr",     1, A_CTRL, 32'h33,         4'h1, 32'h0));
      tbl.push_back(mk("ctrl_readback",   0, A_CTRL, 32'h0,          4'hF, 32'h31));
      tbl.push_back(mk("empty_data_rd",   0, A_DATA, 32'h0,          4'hF, 32'h0));
      tbl.push_back(mk("unf_set",         0, A_STAT, 32'h0,          4'hF, 32'h0000_0900));
      tbl.push_back(mk("stat_wr_noflag",  1, A_STAT, 32'h0000_03FF,  4'hF, 32'h0));
      tbl.push_back(mk("unf_kept",        0, A_STAT, 32'h0,          4'hF, 32'h0000_0900));
      tbl.push_back(mk("unf_w1c",         1, A_STAT, 32'h0000_0800,  4'hF, 32'h0));
      tbl.push_back(mk("unf_cleared",     0, A_STAT, 32'h0,          4'hF, 32'h0000_0100));
      tbl.push_back(mk("ctrl_en",         1, A_CTRL, 32'h01,         4'h1, 32'h0));
      foreach (tbl[i]) begin
         wb(tbl[i].wr, tbl[i].off, tbl[i].wd, tbl[i].sl, rd);
         if (!tbl[i].wr) chk(tbl[i].nm, rd, tbl[i].exp);
      end

      // ---------------- address miss / no cyc ----------------
      any_ack = 1'b0;
      cyc = 1'b1; stb = 1'b1; adr = {4'h2, 24'h0, A_STAT, 2'b00};
      repeat (3) begin step(); any_ack |= ack; end
      cyc = 1'b0; adr = {BASE, 24'h0, A_STAT, 2'b00};
      repeat (3) begin step(); any_ack |= ack; end
      stb = 1'b0;
      step();
      chk("miss_no_ack", {31'b0, any_ack}, 32'h0);

      // ---------------- single word 1010_0110 ----------------
      send_bits(32'hA6, 8);
      rd_reg(A_STAT, rd);  chk("word_count1", rd, 32'h0000_0001);
      rd_reg(A_DATA, rd);  chk("word_a6", rd, 32'h0000_00A6);
      rd_reg(A_STAT, rd);  chk("word_count0", rd, 32'h0000_0100);

      // ---------------- overflow / underflow ----------------
      for (int i = 0; i < 9; i++) send_bits(32'(8'h40 + 8'(i * 7)), 8);
      rd_reg(A_STAT, rd);  chk("ovf_status", rd, 32'h0000_0608);
      for (int i = 0; i < 8; i++) begin
         rd_reg(A_DATA, rd);
         chk($sformatf("ovf_order%0d", i), rd, 32'(8'h40 + 8'(i * 7)));
      end
      rd_reg(A_DATA, rd);  chk("ninth_read", rd, 32'h0);
      rd_reg(A_STAT, rd);  chk("ovf_unf_status", rd, 32'h0000_0D00);
      wr_reg(A_STAT, 32'h0000_0C00);
      rd_reg(A_STAT, rd);  chk("ovf_unf_cleared", rd, 32'h0000_0100);

      // ---------------- irq threshold ----------------
      wr_reg(A_CTRL, 32'h31);
      send_bits(32'h11, 8);
      send_bits(32'h22, 8);
      step();
      chk("irq_below_thr", {31'b0, irq}, 32'h0);
      send_bits(32'h33, 8);
      chk("irq_lag", {31'b0, irq}, 32'h0);
      step();
      chk("irq_rise", {31'b0, irq}, 32'h1);
      rd_reg(A_DATA, rd);  chk("irq_pop_data", rd, 32'h11);
      chk("irq_fall", {31'b0, irq}, 32'h0);
      rd_reg(A_DATA, rd);  chk("irq_pop2", rd, 32'h22);
      rd_reg(A_DATA, rd);  chk("irq_pop3", rd, 32'h33);

      // ---------------- clear mid-word ----------------
      wr_reg(A_CTRL, 32'h01);
      send_bits(32'h15, 5);
      wr_reg(A_CTRL, 32'h03);
      rd_reg(A_STAT, rd);  chk("clr_count0", rd, 32'h0000_0100);
      rd_reg(A_CTRL, rd);  chk("clr_selfclear", rd, 32'h01);
      send_bits(32'h5C, 8);
      rd_reg(A_DATA, rd);  chk("clr_clean_word", rd, 32'h5C);

      // ---------------- full + simultaneous push/pop ----------------
      for (int i = 0; i < 8; i++) begin
         w5[i] = 8'($urandom);
         send_bits(32'(w5[i]), 8);
      end
      w9 = 8'($urandom);
      send_bits(32'(w9[7:1]), 7);
      s_valid = 1'b1; s_data = w9[0];
      cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = {BASE, 24'h0, A_DATA, 2'b00};
      step();
      s_valid = 1'b0;
      chk("same_cyc_ack", {31'b0, ack}, 32'h1);
      chk("same_cyc_data", dat_o, 32'(w5[0]));
      cyc = 1'b0; stb = 1'b0;
      step();
      rd_reg(A_STAT, rd);  chk("same_cyc_status", rd, 32'h0000_0208);
      for (int i = 1; i < 8; i++) begin
         rd_reg(A_DATA, rd);
         chk($sformatf("same_cyc_order%0d", i), rd, 32'(w5[i]));
      end
      rd_reg(A_DATA, rd);  chk("same_cyc_last", rd, 32'(w9));
      rd_reg(A_STAT, rd);  chk("same_cyc_empty", rd, 32'h0000_0100);

      // ---------------- disable mid-word holds partial bits ----------------
      send_bits(32'hB, 4);
      wr_reg(A_CTRL, 32'h00);
      send_bits(32'hFF, 8);
      rd_reg(A_STAT, rd);  chk("dis_ignored", rd, 32'h0000_0100);
      wr_reg(A_CTRL, 32'h01);
      send_bits(32'h2, 4);
      rd_reg(A_DATA, rd);  chk("dis_hold_word", rd, 32'hB2);

      // ---------------- reset mid-word discards partial bits ----------------
      send_bits(32'h7, 3);
      rst = 1'b1; step(); rst = 1'b0; step();
      rd_reg(A_CTRL, rd);  chk("rst_mid_ctrl", rd, 32'h0);
      wr_reg(A_CTRL, 32'h01);
      send_bits(32'h96, 8);
      rd_reg(A_DATA, rd);  chk("rst_mid_word", rd, 32'h96);

      // ---------------- idle timeout ----------------
      send_bits(32'h5, 3);
      repeat (1030) step();
      rd_reg(A_STAT, rd);
`ifdef RLBP_S2P_TIMEOUT_EN
      chk("tmo_ferr", rd, 32'h0000_1100);
      send_bits(32'h3C, 8);
      rd_reg(A_DATA, rd);  chk("tmo_clean_word", rd, 32'h3C);
      wr_reg(A_STAT, 32'h0000_1000);
      rd_reg(A_STAT, rd);  chk("tmo_ferr_clr", rd, 32'h0000_0100);
`else
      chk("tmo_none", rd, 32'h0000_0100);
      send_bits(32'h3C, 8);
      cat = {3'b101, 8'h3C};
      exp8 = cat[10:3];
      rd_reg(A_DATA, rd);  chk("tmo_partial_kept", rd, 32'(exp8));
      wr_reg(A_CTRL, 32'h03);
      rd_reg(A_STAT, rd);  chk("tmo_flush", rd, 32'h0000_0100);
`endif

      // ---------------- randomized vs. word-level model ----------------
      thr = $urandom_range(1, 8);
      wr_reg(A_CTRL, 32'(thr << 4) | 32'h1);
      m_ovf = 0; m_unf = 0;
      for (int it = 0; it < 160; it++) begin
         if ($urandom_range(0, 1) == 0) begin
            rw = 8'($urandom);
            send_bits(32'(rw), 8);
            if (q.size() == 8) m_ovf = 1;
            else q.push_back(rw);
         end else begin
            rd_reg(A_DATA, rd);
            if (q.size() == 0) begin
               m_unf = 1;
               chk("rnd_empty_read", rd, 32'h0);
            end else begin
               exp8 = q.pop_front();
               chk("rnd_data", rd, 32'(exp8));
            end
         end
         step();
         chk("rnd_irq", {31'b0, irq}, {31'b0, (q.size() >= thr)});
         if (it % 4 == 3) begin
            rd_reg(A_STAT, rd);
            chk("rnd_status", rd, 32'(q.size()) | (q.size() == 0 ? 32'h100 : 32'h0)
                                | (q.size() == 8 ? 32'h200 : 32'h0)
                                | (m_ovf ? 32'h400 : 32'h0) | (m_unf ? 32'h800 : 32'h0));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/rlbp_s2p_fifo.md
Name: rlbp_s2p_fifo

Overview:
- Downstream consumer of the RLBP macro's serial code output.
- Reassembles the bit stream into WORD_BITS-wide codes and buffers them in a small FIFO.
- Exposes the codes to the management SoC as Wishbone registers: pop-on-read DATA, plus STATUS and CTRL.
- Raises an interrupt when the FIFO fill level reaches a programmable threshold.

Parameters:
- WORD_BITS, 8, bits per deserialized code (valid range 2..16).
- DEPTH_LOG2, 3, FIFO depth = 2**DEPTH_LOG2 entries.
- BASE_NIBBLE, 4'h3, required value of wbs_adr_i[31:28] for a slave hit.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  reset; synchronous, active-high.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte selects.
- wbs_dat_i  in  32  write data.
- wbs_adr_i  in  32  address; [3:2] selects the register.
- wbs_ack_o  out  1  one-cycle acknowledge.
- wbs_dat_o  out  32  read data.
- s_data_in  in  1  serial code bit, MSB first.
- s_valid_in  in  1  qualifies s_data_in for one cycle.
- irq_o  out  1  level interrupt.

Behaviour:
- Reset: wbs_ack_o=0, wbs_dat_o=0, irq_o=0. FIFO empty, shift count 0, all sticky flags 0, CTRL=0 (block disabled).
- Register map, selected by adr[3:2]:
  - 0 DATA (RO): read returns the head entry zero-extended and pops; empty read returns 0, no pop, sets sticky UNDERFLOW.
  - 1 STATUS: [DEPTH_LOG2:0] count, [8] empty, [9] full, [10] OVERFLOW, [11] UNDERFLOW, [12] FRAME_ERR. Writing 1 to bits 10..12 clears the corresponding flag.
  - 2 CTRL: [0] enable, [1] clear (self-clearing; flushes FIFO and shifter), [7:4] irq threshold.
  - 3: reads 0, writes ignored.
- CTRL writes take effect only when wbs_sel_i[0]=1.
- Wishbone timing:
  - Hit = cyc & stb & (adr[31:28]==BASE_NIBBLE).
  - wbs_ack_o pulses exactly one cycle after the hit cycle; wbs_dat_o is valid in that same cycle.
  - No back-to-back ack: ack is suppressed in the cycle following an ack, so each transfer costs 2 cycles.
  - Pop and sticky-flag side effects occur exactly once per transfer.
- Deserializer:
  - When enable=1 and s_valid_in=1: shreg <= {shreg[WORD_BITS-2:0], s_data_in}, cnt++.
  - When cnt reaches WORD_BITS-1 together with a valid bit, the completed word is pushed the same cycle and cnt wraps to 0.
  - Word latency: last bit to visible in count = 1 cycle.
  - s_valid_in is ignored while enable=0.
- FIFO:
  - Push when full: word dropped, OVERFLOW set, contents unchanged.
  - Push and pop in the same cycle when full: both happen, OVERFLOW not set.
  - Push and pop in the same cycle when empty: no pass-through; pop sees empty and sets UNDERFLOW, push is stored.
  - Pointers wrap modulo depth; count is DEPTH_LOG2+1 bits.
- irq_o = enable & (count >= threshold) & (threshold != 0), registered, so it lags count by 1 cycle.
- Clear has priority over a simultaneous push; flags are untouched by clear.
- Reset mid-word discards the partial bits. Clearing enable mid-word holds the partial bits.

Optional Feature:
- Macro: RLBP_S2P_TIMEOUT_EN.
- Defined:
  - A 16-bit idle counter restarts on each accepted bit.
  - If cnt != 0 and 1024 cycles pass without a valid bit, the partial word is discarded, cnt is set to 0, and FRAME_ERR is set.
- Undefined:
  - No counter is built; partial words persist indefinitely.
  - STATUS[12] reads 0.

Decomposition:
- Package rlbp_s2p_pkg holds: register offsets (DATA/STATUS/CTRL/RSV), STATUS/CTRL bit positions, and the timeout constant.
- Sub-module rlbp_sync_fifo (parameters WIDTH, DEPTH_LOG2; push/pop/full/empty/count) is instantiated once.
- The deserializer and Wishbone logic stay in the top module.

Test Plan:
- Enable, send serial 1010_0110 → STATUS count=1; DATA read returns 0x000000A6; count=0 afterwards.
- Send 9 words with threshold 0: first 8 stored, 9th dropped, OVERFLOW=1. Eight reads return the words in order; 9th read returns 0 and UNDERFLOW=1. W1C of 0xC00 clears both flags.
- Threshold=3, push 3 words → irq_o rises 1 cycle after the 3rd push; one DATA read → irq_o falls.
- Push 5 bits, then write CTRL clear=1 → count=0. Next 8 bits form a clean word.
- FIFO full, with a pop and a push landing in the same cycle → count stays 8, OVERFLOW=0, order preserved.
- TIMEOUT_EN defined: send 3 bits, idle 1024 cycles → FRAME_ERR=1; next 8 bits yield the correct word. Undefined: partial bits are kept and FRAME_ERR=0.
